split_sample_ctrl: RTL
======================

Name: split_sample_ctrl

Overview:
- Upstream driver for the split constraint evaluators (split_0..split_N).
- Fills the packed 654-bit candidate variable bus (var_0..var_19 concatenated) from a 64-bit LFSR, one word per cycle.
- Waits the evaluators' settle latency, then ANDs their x outputs.
- Re-samples until every split accepts, or until a retry budget is exhausted.

Parameters:
- VAR_BITS, 654: total width of the packed variable bus. var_0 occupies bits [26:0], then var_1 above it, and so on up to var_19 at the MSB end.
- NUM_SPLITS, 8: number of split evaluator x outputs that are ANDed together.
- EVAL_LAT, 1: cycles between var_bus becoming stable and split_ok being valid. Must be ≥1.
- MAX_TRIES, 1024: attempt budget. Must be ≥1.
- TRY_W, 16: width of the attempt counter. Must satisfy 2^TRY_W > MAX_TRIES.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle request; accepted only in IDLE.
- seed, input, 64: LFSR seed, captured on the accepting start.
- split_ok, input, NUM_SPLITS: x outputs of the split evaluators.
- var_bus, output, VAR_BITS: candidate assignment driven to the splits.
- busy, output, 1: high in FILL, EVAL and CHECK.
- done, output, 1: one-cycle pulse when a search finishes (found or exhausted).
- found, output, 1: level; 1 means var_bus holds a satisfying assignment. Valid from the done cycle until the next accepted start.
- attempts, output, TRY_W: number of candidates evaluated in the current or last search.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, var_bus=0, busy=0, done=0, found=0, attempts=0, LFSR=64'h1, fill index=0, eval counter=0.
- LFSR: 64-bit Galois form, shifts right. Each step: lfsr_next = (lfsr>>1) ^ (lfsr[0] ? 64'hD800_0000_0000_0000 : 0). A seed of 0 is replaced by 64'h1.
- WORDS = ceil(VAR_BITS/64) = 11.
- IDLE: start=1 does the following, then moves to FILL:
  - captures the seed into the LFSR;
  - clears attempts and found;
  - clears fill index w.
  - start is ignored in every other state.
- FILL: one cycle per word.
  - Each cycle: LFSR steps, and lfsr_next is written to var_bus[64w +: 64], clipped at VAR_BITS (word 10 writes 14 bits).
  - After w=WORDS-1, go to EVAL with the eval counter cleared.
- EVAL: hold var_bus constant for EVAL_LAT cycles, then go to CHECK.
- CHECK: attempts increments by 1 (saturating at MAX_TRIES). Then:
  - &split_ok=1 → DONE with found=1.
  - else, if the new attempts==MAX_TRIES → DONE with found=0.
  - else → FILL with w=0. The LFSR continues from its current state and is not reseeded.
- DONE: done=1 for exactly one cycle, then IDLE. var_bus, found and attempts hold until the next accepted start.
- split_ok is sampled only in CHECK; values in other states are ignored.
- Latency: start accepted at cycle t → FILL t+1..t+11, EVAL t+12..t+11+EVAL_LAT, CHECK t+12+EVAL_LAT, done at t+13+EVAL_LAT. Each retry adds 11+EVAL_LAT+1 cycles.
- Reset mid-search: immediate return to reset values. No done pulse is issued.
- start asserted in the same cycle as done: ignored, because the FSM is not yet in IDLE.

Decomposition:
- split_pkg holds:
  - VAR_BITS and WORDS;
  - per-variable offset and width localparams (VAR0_OFF=0/W=27 … VAR19_OFF=634/W=20);
  - LFSR_MASK;
  - the state enum {IDLE, FILL, EVAL, CHECK, DONE}.
- Sub-module split_lfsr64 contains:
  - the seedable 64-bit Galois LFSR, with clk, rst, load, seed, step and value;
  - the zero-seed guard.

Test Plan:
- split_ok tied all-ones, seed=64'h1, start at t → done and found=1 at t+14, attempts=1. var_bus[63:0]=64'hD800_0000_0000_0000, which is the first LFSR step from 1.
- split_ok tied 0, MAX_TRIES=4 → done at t+14+3·13=t+53, found=0, attempts=4. busy high t+1..t+52.
- split_ok all-ones only during the third CHECK → found=1, attempts=3. var_bus equals the LFSR steps 23..33 of the reference model.
- seed=0 → identical var_bus sequence to seed=64'h1.
- rst asserted during EVAL of attempt 2 → all outputs 0 asynchronously, no done pulse. A new start then behaves as in scenario 1.
- start pulsed during FILL and on the done cycle → no effect on sequence or attempts. A start one cycle after done launches a new search.

Source files
------------

// File: rtl/split_pkg.sv
// Shared constants, variable layout, FSM states and LFSR step for the split sampler.
package split_pkg;

  localparam int unsigned VAR_BITS = 654;
  localparam int unsigned WORDS    = (VAR_BITS + 63) / 64;

  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

  // Packed layout of var_0..var_19 inside var_bus (var_0 at the LSB end)
  localparam int unsigned VAR0_W  = 27, VAR0_OFF  = 0;
  localparam int unsigned VAR1_W  = 34, VAR1_OFF  = VAR0_OFF  + VAR0_W;
  localparam int unsigned VAR2_W  = 34, VAR2_OFF  = VAR1_OFF  + VAR1_W;
  localparam int unsigned VAR3_W  = 34, VAR3_OFF  = VAR2_OFF  + VAR2_W;
  localparam int unsigned VAR4_W  = 34, VAR4_OFF  = VAR3_OFF  + VAR3_W;
  localparam int unsigned VAR5_W  = 34, VAR5_OFF  = VAR4_OFF  + VAR4_W;
  localparam int unsigned VAR6_W  = 34, VAR6_OFF  = VAR5_OFF  + VAR5_W;
  localparam int unsigned VAR7_W  = 34, VAR7_OFF  = VAR6_OFF  + VAR6_W;
  localparam int unsigned VAR8_W  = 34, VAR8_OFF  = VAR7_OFF  + VAR7_W;
  localparam int unsigned VAR9_W  = 34, VAR9_OFF  = VAR8_OFF  + VAR8_W;
  localparam int unsigned VAR10_W = 34, VAR10_OFF = VAR9_OFF  + VAR9_W;
  localparam int unsigned VAR11_W = 34, VAR11_OFF = VAR10_OFF + VAR10_W;
  localparam int unsigned VAR12_W = 34, VAR12_OFF = VAR11_OFF + VAR11_W;
  localparam int unsigned VAR13_W = 34, VAR13_OFF = VAR12_OFF + VAR12_W;
  localparam int unsigned VAR14_W = 34, VAR14_OFF = VAR13_OFF + VAR13_W;
  localparam int unsigned VAR15_W = 34, VAR15_OFF = VAR14_OFF + VAR14_W;
  localparam int unsigned VAR16_W = 34, VAR16_OFF = VAR15_OFF + VAR15_W;
  localparam int unsigned VAR17_W = 34, VAR17_OFF = VAR16_OFF + VAR16_W;
  localparam int unsigned VAR18_W = 29, VAR18_OFF = VAR17_OFF + VAR17_W;
  localparam int unsigned VAR19_W = 20, VAR19_OFF = VAR18_OFF + VAR18_W;

  typedef enum logic [2:0] {IDLE, FILL, EVAL, CHECK, DONE} state_t;

  // One right-shifting Galois step
  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 64'h0);
  endfunction

endpackage

// File: rtl/split_lfsr64.sv
// Seedable 64-bit Galois LFSR; an all-zero seed is replaced by 1 so it never locks up.
module split_lfsr64
  import split_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] value
);

  // Load takes priority over step; reset state is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 64'h1;
    end else if (load) begin
      value <= (seed == 64'h0) ? 64'h1 : seed;
    end else if (step) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/split_sample_ctrl.sv
// Fills the split evaluators' variable bus from the LFSR and retries until all splits accept.
module split_sample_ctrl
  import split_pkg::*;
#(
  parameter int unsigned VAR_BITS   = split_pkg::VAR_BITS,
  parameter int unsigned NUM_SPLITS = 8,
  parameter int unsigned EVAL_LAT   = 1,
  parameter int unsigned MAX_TRIES  = 1024,
  parameter int unsigned TRY_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [63:0]           seed,
  input  logic [NUM_SPLITS-1:0] split_ok,
  output logic [VAR_BITS-1:0]   var_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [TRY_W-1:0]      attempts
);

  localparam int unsigned NWORDS = (VAR_BITS + 63) / 64;
  localparam int unsigned IDX_W  = $clog2(NWORDS);
  localparam int unsigned EC_W   = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

  state_t              state, state_next;
  logic [IDX_W-1:0]    w;
  logic [EC_W-1:0]     eval_cnt;
  logic [63:0]         lfsr_value, lfsr_next;
  logic                accept, fill_last, eval_last, all_ok, budget_out;
  logic [TRY_W-1:0]    attempts_inc;
  logic [VAR_BITS-1:0] word_mask, word_data;

  split_lfsr64 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .seed  (seed),
    .step  (state == FILL),
    .value (lfsr_value)
  );

  assign lfsr_next  = lfsr_step(lfsr_value);
  // Shifting a 64-bit window left by 64*w clips the last word at VAR_BITS for free
  assign word_mask  = {{(VAR_BITS-64){1'b0}}, {64{1'b1}}} << {w, 6'd0};
  assign word_data  = {{(VAR_BITS-64){1'b0}}, lfsr_next} << {w, 6'd0};
  assign fill_last  = (w == IDX_W'(NWORDS - 1));
  assign eval_last  = (eval_cnt == EC_W'(EVAL_LAT - 1));
  assign all_ok     = &split_ok;
  assign attempts_inc = (attempts < TRY_W'(MAX_TRIES)) ? attempts + TRY_W'(1) : attempts;
  assign budget_out = (attempts_inc == TRY_W'(MAX_TRIES));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        busy = 1'b1;
        if (fill_last) state_next = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (eval_last) state_next = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (all_ok || budget_out) state_next = DONE;
        else                      state_next = FILL;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: bus fill, counters and search result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      var_bus  <= '0;
      found    <= 1'b0;
      attempts <= '0;
      w        <= '0;
      eval_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            found    <= 1'b0;
            attempts <= '0;
            w        <= '0;
          end
        end
        FILL: begin
          var_bus <= (var_bus & ~word_mask) | word_data;
          if (fill_last) begin
            w        <= '0;
            eval_cnt <= '0;
          end else begin
            w <= w + IDX_W'(1);
          end
        end
        EVAL: eval_cnt <= eval_cnt + EC_W'(1);
        CHECK: begin
          attempts <= attempts_inc;
          w        <= '0;
          if (all_ok) found <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
